// File: rtl/perceptron_predictor_mc_pkg.sv
// Shared types, widths and weight arithmetic helpers for the perceptron branch predictor.
package perceptron_predictor_mc_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned HIST_LEN   = 32;
  localparam int unsigned TBL_DEPTH  = 256;
  localparam int unsigned W_BITS     = 8;
  localparam int unsigned FB_ENTRIES = 4;
  localparam int unsigned META_IDX_W = $clog2(TBL_DEPTH);
  localparam int unsigned META_SUM_W = W_BITS + $clog2(HIST_LEN + 1) + 1;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef logic signed [W_BITS-1:0]     weight_t;
  typedef logic signed [META_SUM_W-1:0] sum_t;

  typedef struct packed {
    logic [META_IDX_W-1:0] index;
    logic [HIST_LEN-1:0]   history;
    sum_t                  sum;
  } perceptron_meta_t;

  typedef struct packed {
    perceptron_meta_t meta;
    BranchOutcome     prediction;
    BranchOutcome     outcome;
  } perceptron_fb_t;

  // Clamp a one-bit-wider weight back into the signed weight range.
  function automatic weight_t saturate(input logic [W_BITS:0] v);
    if (v[W_BITS] != v[W_BITS-1]) begin
      return v[W_BITS] ? weight_t'({1'b1, {(W_BITS-1){1'b0}}})
                       : weight_t'({1'b0, {(W_BITS-1){1'b1}}});
    end
    return weight_t'(v[W_BITS-1:0]);
  endfunction

  // Step a weight by +1/-1 with saturation.
  function automatic weight_t nudge(input weight_t w, input logic up);
    logic [W_BITS:0] wide;
    wide = {w[W_BITS-1], w};
    wide = up ? wide + (W_BITS+1)'(1) : wide - (W_BITS+1)'(1);
    return saturate(wide);
  endfunction

  // The sum carries a guard bit, so negating any reachable value cannot overflow.
  function automatic logic [META_SUM_W-1:0] abs_sum(input sum_t s);
    return s[META_SUM_W-1] ? META_SUM_W'(-s) : META_SUM_W'(s);
  endfunction

endpackage

// File: rtl/perceptron_predictor_mc_if.sv
// Fetch-side request and resolve-side feedback bundle of the perceptron predictor.
interface perceptron_predictor_mc_if;
  import perceptron_predictor_mc_pkg::*;

  logic                   i_req_valid;
  logic [ADDR_WIDTH-1:0]  i_req_pc;
  BranchOutcome           o_req_prediction;
  perceptron_meta_t       o_req_meta;
  logic                   o_init_done;
  logic                   i_fb_valid;
  logic                   o_fb_ready;
  perceptron_meta_t       i_fb_meta;
  BranchOutcome           i_fb_prediction;
  BranchOutcome           i_fb_outcome;

  modport master (
    output i_req_valid, i_req_pc, i_fb_valid, i_fb_meta, i_fb_prediction, i_fb_outcome,
    input  o_req_prediction, o_req_meta, o_init_done, o_fb_ready
  );

  modport slave (
    input  i_req_valid, i_req_pc, i_fb_valid, i_fb_meta, i_fb_prediction, i_fb_outcome,
    output o_req_prediction, o_req_meta, o_init_done, o_fb_ready
  );
endinterface

// File: rtl/perceptron_predictor_mc_fb_fifo.sv
// Generic ready/valid synchronous FIFO; no pass-through, so a push into an empty FIFO pops next cycle.
module perceptron_fb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: rtl/perceptron_predictor_mc.sv
// Perceptron branch predictor: speculative GHR with mispredict repair, meta-driven training
// through a feedback FIFO, and a row-by-row table clear after reset.
module perceptron_predictor_mc
  import perceptron_predictor_mc_pkg::*;
#(
  parameter int unsigned HISTORY_SIZE = HIST_LEN,
  parameter int unsigned TABLE_DEPTH  = TBL_DEPTH,
  parameter int unsigned WEIGHT_BITS  = W_BITS,
  parameter int unsigned THRESHOLD    = (193 * HISTORY_SIZE + 1450) / 100,
  parameter int unsigned FB_DEPTH     = FB_ENTRIES
) (
  input  logic                      clk,
  input  logic                      rst,
  perceptron_predictor_mc_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(TABLE_DEPTH);
  localparam int unsigned SUM_W = WEIGHT_BITS + $clog2(HISTORY_SIZE + 1) + 1;
  localparam int unsigned EXT_W = (HISTORY_SIZE > IDX_W) ? HISTORY_SIZE : IDX_W;
  localparam int unsigned NW    = HISTORY_SIZE + 1;
  localparam int unsigned FB_W  = $bits(perceptron_fb_t);

  typedef enum logic { ST_INIT, ST_RUN } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         init_cnt_q, init_cnt_d;
  logic [HISTORY_SIZE-1:0]  ghr_q, ghr_d;
  weight_t                  weights_q [TABLE_DEPTH][NW];

  logic                     run;
  logic [EXT_W-1:0]         ghr_ext;
  logic [IDX_W-1:0]         req_idx;
  logic signed [SUM_W-1:0]  req_sum;
  BranchOutcome             req_pred;
  perceptron_meta_t         req_meta;
  logic                     unused_pc;

  logic                     fifo_in_ready, pop_valid, fb_push, train;
  perceptron_fb_t           fb_in, pop_entry;
  logic [FB_W-1:0]          pop_data;
  weight_t                  new_row [NW];

  assign run       = (state_q == ST_RUN);
  assign unused_pc = ^{bus.i_req_pc[ADDR_WIDTH-1:IDX_W+2], bus.i_req_pc[1:0]};

  // Index hash and perceptron dot product for the fetch-stage request.
  always_comb begin
    ghr_ext = EXT_W'(ghr_q);
    req_idx = bus.i_req_pc[IDX_W+1:2] ^ ghr_ext[IDX_W-1:0];
    req_sum = SUM_W'(weights_q[req_idx][0]);
    for (int i = 1; i < NW; i++) begin
      if (ghr_q[i-1]) req_sum = req_sum + SUM_W'(weights_q[req_idx][i]);
      else            req_sum = req_sum - SUM_W'(weights_q[req_idx][i]);
    end
  end

  always_comb begin
    req_meta = '0;
    req_pred = NOT_TAKEN;
    if (run) begin
      req_meta.index   = req_idx;
      req_meta.history = ghr_q;
      req_meta.sum     = req_sum;
      req_pred         = req_sum[SUM_W-1] ? NOT_TAKEN : TAKEN;
    end
  end

  assign bus.o_req_prediction = req_pred;
  assign bus.o_req_meta       = req_meta;
  assign bus.o_init_done      = run;
  assign bus.o_fb_ready       = run && fifo_in_ready;
  assign fb_push              = bus.i_fb_valid && bus.o_fb_ready;

  assign fb_in = '{meta: bus.i_fb_meta, prediction: bus.i_fb_prediction, outcome: bus.i_fb_outcome};

  perceptron_fb_fifo #(
    .WIDTH (FB_W),
    .DEPTH (FB_DEPTH)
  ) u_fb_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.i_fb_valid && run),
    .in_ready  (fifo_in_ready),
    .in_data   (fb_in),
    .out_valid (pop_valid),
    .out_ready (run),
    .out_data  (pop_data)
  );

  assign pop_entry = pop_data;

  // Training decision and updated row, from the popped meta record only.
  always_comb begin
    train = pop_valid && run &&
            ((pop_entry.prediction != pop_entry.outcome) ||
             (abs_sum(pop_entry.meta.sum) <= SUM_W'(THRESHOLD)));
    new_row[0] = nudge(weights_q[pop_entry.meta.index][0], pop_entry.outcome == TAKEN);
    for (int i = 1; i < NW; i++) begin
      new_row[i] = nudge(weights_q[pop_entry.meta.index][i],
                         pop_entry.meta.history[i-1] == (pop_entry.outcome == TAKEN));
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int i = 0; i < NW; i++) weights_q[init_cnt_q][i] <= '0;
    end else if (train) begin
      for (int i = 0; i < NW; i++) weights_q[pop_entry.meta.index][i] <= new_row[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ghr_q      <= ghr_d;
    end
  end

  // Clear sequencing and speculative history; a repair overrides a same-cycle request shift.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ghr_d      = ghr_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == IDX_W'(TABLE_DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fb_push && (bus.i_fb_outcome != bus.i_fb_prediction)) begin
          ghr_d = {bus.i_fb_meta.history[HISTORY_SIZE-2:0], bus.i_fb_outcome == TAKEN};
        end else if (bus.i_req_valid) begin
          ghr_d = {ghr_q[HISTORY_SIZE-2:0], req_pred == TAKEN};
        end
      end
    endcase
  end
endmodule
